// File: rtl/ulpi_rx_packetizer.sv
// ulpi_rx_packetizer
//   Receive-side ULPI packetizer. While the PHY owns the bus (dir=1) it
//   separates RX_CMD bytes (nxt=0) from packet bytes (nxt=1), assembles
//   one USB packet (PID plus up to MAX_PAYLOAD payload bytes and CRC16),
//   classifies it and presents it as one packed word with a one-cycle
//   strobe. Line state is tracked from every accepted RX_CMD.
//
// Ports
//   usb_clk         ULPI 60 MHz clock, all logic on posedge
//   rst             asynchronous active-high reset
//   dir_i, nxt_i    ULPI bus direction / next
//   data_i[7:0]     ULPI data bus
//   pkt_data_o      payload, byte0 in [7:0]; unused bytes are zero
//   pkt_len_o       payload byte count (CRC bytes excluded)
//   pkt_pid_o       PID[3:0] of the emitted packet
//   pkt_valid_o     one-cycle strobe; pkt_* held until the next strobe
//   pkt_crc_err_o   CRC16 residual mismatch (data PIDs only)
//   pkt_pid_err_o   bad PID check nibble, or illegal PID type / length
//   pkt_ovf_o       more than MAX_PAYLOAD+2 bytes followed the PID
//   rx_active_o     packet in progress
//   linestate_o     RX_CMD[1:0] of the most recent RX_CMD
//   rx_cmd_valid_o  one-cycle strobe per accepted RX_CMD
module ulpi_rx_packetizer #(
    parameter int unsigned MAX_PAYLOAD = 8
) (
    input  logic                     usb_clk,
    input  logic                     rst,
    input  logic                     dir_i,
    input  logic                     nxt_i,
    input  logic [7:0]               data_i,
    output logic [8*MAX_PAYLOAD-1:0] pkt_data_o,
    output logic [3:0]               pkt_len_o,
    output logic [3:0]               pkt_pid_o,
    output logic                     pkt_valid_o,
    output logic                     pkt_crc_err_o,
    output logic                     pkt_pid_err_o,
    output logic                     pkt_ovf_o,
    output logic                     rx_active_o,
    output logic [1:0]               linestate_o,
    output logic                     rx_cmd_valid_o
);

    localparam int unsigned BUF_BYTES = MAX_PAYLOAD + 2;
    localparam logic [3:0]  N_BUF     = 4'(BUF_BYTES);
    localparam logic [3:0]  N_OVF     = 4'(BUF_BYTES + 1);
    localparam logic [3:0]  LEN_MAX   = 4'(MAX_PAYLOAD);

    typedef enum logic [2:0] {ST_IDLE, ST_TURN, ST_LISTEN, ST_PKT, ST_EMIT} state_t;

    state_t      r_state, w_state, w_next;
    logic [7:0]  r_pid;
    logic [7:0]  r_buf [BUF_BYTES];
    logic [3:0]  r_n;
    logic [15:0] r_crc;

    logic [8*MAX_PAYLOAD-1:0] r_pkt_data, w_data;
    logic [3:0]  r_pkt_len, r_pkt_pid, w_len;
    logic        r_pkt_valid, r_crc_err, r_pid_err, r_ovf;
    logic        w_crc_err, w_pid_err, w_ovf;
    logic [1:0]  r_linestate;
    logic        r_rx_cmd_valid;
    logic        w_rxcmd, w_start, w_append, w_end;

    // Reflected CRC16 (poly 0xA001), one byte LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int unsigned b = 0; b < 8; b++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    // The state register holds IDLE during the first dir=1 cycle; that
    // sampled cycle is the turnaround, so it is decoded as TURN here.
    always_comb begin
        w_state  = r_state;
        if (r_state == ST_IDLE && dir_i)
            w_state = ST_TURN;
        w_next   = w_state;
        w_rxcmd  = 1'b0;
        w_start  = 1'b0;
        w_append = 1'b0;
        w_end    = 1'b0;
        case (w_state)
            ST_IDLE:   w_next = ST_IDLE;
            ST_TURN:   w_next = dir_i ? ST_LISTEN : ST_IDLE;
            ST_LISTEN: begin
                if (!dir_i)
                    w_next = ST_IDLE;
                else if (nxt_i) begin
                    w_start = 1'b1;
                    w_next  = ST_PKT;
                end else
                    w_rxcmd = 1'b1;
            end
            ST_PKT: begin
                if (!dir_i) begin
                    w_end  = 1'b1;
                    w_next = ST_EMIT;
                end else if (nxt_i)
                    w_append = 1'b1;
                else begin
                    w_rxcmd = 1'b1;
                    if (!data_i[4]) begin
                        w_end  = 1'b1;
                        w_next = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                w_rxcmd = dir_i && !nxt_i;
                w_next  = dir_i ? ST_LISTEN : ST_IDLE;
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    // Packet classification from the current buffer; latched at end of packet.
    always_comb begin
        w_ovf     = (r_n == N_OVF);
        w_pid_err = (r_pid[7:4] != ~r_pid[3:0]);
        w_len     = '0;
        w_crc_err = 1'b0;
        w_data    = '0;
        case (r_pid[1:0])
            2'b11: begin
                if (r_n >= 4'd2) begin
                    w_len     = r_n - 4'd2;
                    w_crc_err = (r_crc != 16'hB001);
                end else
                    w_pid_err = 1'b1;
            end
            2'b10:   if (r_n != 4'd0) w_pid_err = 1'b1;
            default: w_pid_err = 1'b1;
        endcase
        if (w_ovf) begin
            w_len     = LEN_MAX;
            w_crc_err = 1'b0;
        end
        for (int unsigned i = 0; i < MAX_PAYLOAD; i++)
            if (4'(i) < w_len)
                w_data[i*8 +: 8] = r_buf[i];
    end

    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_pid          <= '0;
            r_n            <= '0;
            r_crc          <= '1;
            for (int unsigned i = 0; i < BUF_BYTES; i++)
                r_buf[i] <= '0;
            r_pkt_data     <= '0;
            r_pkt_len      <= '0;
            r_pkt_pid      <= '0;
            r_pkt_valid    <= 1'b0;
            r_crc_err      <= 1'b0;
            r_pid_err      <= 1'b0;
            r_ovf          <= 1'b0;
            r_linestate    <= '0;
            r_rx_cmd_valid <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_rx_cmd_valid <= w_rxcmd;
            r_pkt_valid    <= w_end;
            if (w_rxcmd)
                r_linestate <= data_i[1:0];
            if (w_start) begin
                r_pid <= data_i;
                r_n   <= '0;
                r_crc <= '1;
                for (int unsigned i = 0; i < BUF_BYTES; i++)
                    r_buf[i] <= '0;
            end
            if (w_append) begin
                // n saturates one past the buffer size to flag overflow.
                if (r_n != N_OVF)
                    r_n <= r_n + 4'd1;
                if (r_n < N_BUF) begin
                    r_buf[r_n] <= data_i;
                    r_crc      <= crc16_byte(r_crc, data_i);
                end
            end
            if (w_end) begin
                r_pkt_data <= w_data;
                r_pkt_len  <= w_len;
                r_pkt_pid  <= r_pid[3:0];
                r_crc_err  <= w_crc_err;
                r_pid_err  <= w_pid_err;
                r_ovf      <= w_ovf;
            end
        end
    end

    assign pkt_data_o     = r_pkt_data;
    assign pkt_len_o      = r_pkt_len;
    assign pkt_pid_o      = r_pkt_pid;
    assign pkt_valid_o    = r_pkt_valid;
    assign pkt_crc_err_o  = r_crc_err;
    assign pkt_pid_err_o  = r_pid_err;
    assign pkt_ovf_o      = r_ovf;
    assign rx_active_o    = (r_state == ST_PKT);
    assign linestate_o    = r_linestate;
    assign rx_cmd_valid_o = r_rx_cmd_valid;

endmodule

// File: tb/tb_ulpi_rx_packetizer.sv
module tb_ulpi_rx_packetizer;

    logic        usb_clk = 1'b0;
    logic        rst = 1'b1;
    logic        dir_i = 1'b0, nxt_i = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic [63:0] pkt_data_o;
    logic [3:0]  pkt_len_o, pkt_pid_o;
    logic        pkt_valid_o, pkt_crc_err_o, pkt_pid_err_o, pkt_ovf_o;
    logic        rx_active_o, rx_cmd_valid_o;
    logic [1:0]  linestate_o;

    ulpi_rx_packetizer #(.MAX_PAYLOAD(8)) dut (
        .usb_clk(usb_clk), .rst(rst), .dir_i(dir_i), .nxt_i(nxt_i), .data_i(data_i),
        .pkt_data_o(pkt_data_o), .pkt_len_o(pkt_len_o), .pkt_pid_o(pkt_pid_o),
        .pkt_valid_o(pkt_valid_o), .pkt_crc_err_o(pkt_crc_err_o),
        .pkt_pid_err_o(pkt_pid_err_o), .pkt_ovf_o(pkt_ovf_o),
        .rx_active_o(rx_active_o), .linestate_o(linestate_o),
        .rx_cmd_valid_o(rx_cmd_valid_o)
    );

    always #5 usb_clk = ~usb_clk;

    typedef struct packed {
        logic [7:0]  pid;
        logic [3:0]  nb;
        logic [95:0] bytes;      // byte i at [i*8 +: 8]
        logic [1:0]  pre;        // RX_CMD 0x10 cycles before the PID
        logic        term_rx;    // 1: end by RX_CMD term_data, 0: end by dir=0
        logic [7:0]  term_data;
        logic [3:0]  e_pid;
        logic [3:0]  e_len;
        logic [63:0] e_data;
        logic        e_crc, e_pe, e_ovf;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int n_strobe = 0;
    int n_rxcmd = 0;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic d, input logic n, input logic [7:0] x);
        dir_i = d; nxt_i = n; data_i = x;
        @(posedge usb_clk); #1;
        if (pkt_valid_o) n_strobe++;
        if (rx_cmd_valid_o) n_rxcmd++;
    endtask

    // Reference CRC16 (USB, reflected 0xA001, init 0xFFFF) over the first len bytes.
    function automatic logic [95:0] add_crc(input logic [95:0] p, input int unsigned len);
        logic [15:0] c;
        logic [95:0] r;
        c = 16'hFFFF;
        for (int unsigned i = 0; i < len; i++) begin
            c = c ^ {8'h00, p[i*8 +: 8]};
            for (int unsigned b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        c = ~c;
        r = p;
        r[len*8 +: 8]     = c[7:0];
        r[(len+1)*8 +: 8] = c[15:8];
        return r;
    endfunction

    function automatic vec_t mk(input logic [7:0] pid, input logic [3:0] nb, input logic [95:0] bytes,
                                input logic [1:0] pre, input logic term_rx, input logic [7:0] term_data,
                                input logic [3:0] e_pid, input logic [3:0] e_len, input logic [63:0] e_data,
                                input logic e_crc, input logic e_pe, input logic e_ovf);
        vec_t v;
        v.pid = pid; v.nb = nb; v.bytes = bytes; v.pre = pre; v.term_rx = term_rx;
        v.term_data = term_data; v.e_pid = e_pid; v.e_len = e_len; v.e_data = e_data;
        v.e_crc = e_crc; v.e_pe = e_pe; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic run_vec(input int k, input vec_t v);
        n_strobe = 0;
        n_rxcmd  = 0;
        step(1'b1, 1'b0, 8'h03);                 // turnaround: must be ignored
        for (int i = 0; i < int'(v.pre); i++) step(1'b1, 1'b0, 8'h10);
        step(1'b1, 1'b1, v.pid);
        chk($sformatf("v%0d_rx_active", k), 96'(rx_active_o), 96'd1);
        for (int i = 0; i < int'(v.nb); i++) step(1'b1, 1'b1, v.bytes[i*8 +: 8]);
        if (v.term_rx) step(1'b1, 1'b0, v.term_data);
        else           step(1'b0, 1'b0, 8'h00);
        chk($sformatf("v%0d_valid", k),   96'(pkt_valid_o),   96'd1);
        chk($sformatf("v%0d_pid", k),     96'(pkt_pid_o),     96'(v.e_pid));
        chk($sformatf("v%0d_len", k),     96'(pkt_len_o),     96'(v.e_len));
        chk($sformatf("v%0d_data", k),    96'(pkt_data_o),    96'(v.e_data));
        chk($sformatf("v%0d_crc_err", k), 96'(pkt_crc_err_o), 96'(v.e_crc));
        chk($sformatf("v%0d_pid_err", k), 96'(pkt_pid_err_o), 96'(v.e_pe));
        chk($sformatf("v%0d_ovf", k),     96'(pkt_ovf_o),     96'(v.e_ovf));
        if (v.term_rx) chk($sformatf("v%0d_linestate", k), 96'(linestate_o), 96'(v.term_data[1:0]));
        step(1'b0, 1'b0, 8'h00);
        chk($sformatf("v%0d_strobe_1cyc", k), 96'(pkt_valid_o), 96'd0);
        step(1'b0, 1'b0, 8'h00);
        chk($sformatf("v%0d_strobes", k), 96'(n_strobe), 96'd1);
        chk($sformatf("v%0d_rxcmds", k),  96'(n_rxcmd),  96'(int'(v.pre) + int'(v.term_rx)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] good5, good8, good2;
        good5 = add_crc(96'h15_14_13_12_11, 5);
        good8 = add_crc(96'hA7_A6_A5_A4_A3_A2_A1_A0, 8);
        good2 = add_crc(96'h22_21, 2);

        //           pid    nb  bytes                           pre tr  tdat   pid  len  data                    crc pe  ovf
        vecs[0] = mk(8'hD2, 0,  96'h0,                          0, 1, 8'h00, 4'h2, 0, 64'h0,                  0, 0, 0);
        vecs[1] = mk(8'h4B, 2,  96'h00_00,                      0, 1, 8'h09, 4'hB, 0, 64'h0,                  0, 0, 0);
        vecs[2] = mk(8'hC3, 7,  96'hFF_FF_15_14_13_12_11,       3, 1, 8'h09, 4'h3, 5, 64'h00000015_14131211,  1, 0, 0);
        vecs[3] = mk(8'hC3, 7,  good5,                          0, 0, 8'h00, 4'h3, 5, 64'h00000015_14131211,  0, 0, 0);
        vecs[4] = mk(8'h43, 2,  96'h00_00,                      0, 1, 8'h00, 4'h3, 0, 64'h0,                  0, 1, 0);
        vecs[5] = mk(8'hC3, 12, 96'h0C0B0A09_08070605_04030201, 0, 1, 8'h02, 4'h3, 8, 64'h08070605_04030201,  0, 0, 1);
        vecs[6] = mk(8'h4B, 1,  96'h55,                         0, 1, 8'h01, 4'hB, 0, 64'h0,                  0, 1, 0);
        vecs[7] = mk(8'hE1, 2,  96'h10_00,                      0, 0, 8'h00, 4'h1, 0, 64'h0,                  0, 1, 0);
        vecs[8] = mk(8'h5A, 1,  96'h00,                         1, 1, 8'h00, 4'hA, 0, 64'h0,                  0, 1, 0);
        vecs[9] = mk(8'hC3, 10, good8,                          0, 1, 8'h03, 4'h3, 8, 64'hA7A6A5A4_A3A2A1A0,  0, 0, 0);

        // Reset state
        #1;
        chk("reset_outputs", {16'h0, pkt_data_o, pkt_len_o, pkt_pid_o, pkt_valid_o, pkt_crc_err_o,
                              pkt_pid_err_o, pkt_ovf_o, rx_active_o, linestate_o, rx_cmd_valid_o}, 96'h0);
        repeat (2) @(posedge usb_clk);
        #1 rst = 1'b0;
        step(1'b0, 1'b0, 8'h00);

        // RX_CMD only
        n_strobe = 0; n_rxcmd = 0;
        step(1'b1, 1'b0, 8'h03);
        chk("rxcmd_turn_ignored", 96'(rx_cmd_valid_o), 96'd0);
        step(1'b1, 1'b0, 8'h01);
        chk("rxcmd_valid", 96'(rx_cmd_valid_o), 96'd1);
        chk("rxcmd_linestate", 96'(linestate_o), 96'd1);
        step(1'b0, 1'b0, 8'h00);
        chk("rxcmd_valid_1cyc", 96'(rx_cmd_valid_o), 96'd0);
        step(1'b0, 1'b0, 8'h00);
        chk("rxcmd_count", 96'(n_rxcmd), 96'd1);
        chk("rxcmd_no_pkt", 96'(n_strobe), 96'd0);

        for (int k = 0; k < 10; k++) run_vec(k, vecs[k]);
        chk("hold_after_strobe", 96'(pkt_data_o), 96'h A7A6A5A4_A3A2A1A0);

        // RX_CMD with RxActive=1 inside a packet does not end it
        n_strobe = 0;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'hC3);
        step(1'b1, 1'b1, good2[7:0]);
        step(1'b1, 1'b0, 8'h12);
        chk("mid_rxcmd_valid", 96'(rx_cmd_valid_o), 96'd1);
        chk("mid_rxcmd_ls", 96'(linestate_o), 96'd2);
        chk("mid_rxcmd_active", 96'(rx_active_o), 96'd1);
        step(1'b1, 1'b1, good2[15:8]);
        step(1'b1, 1'b1, good2[23:16]);
        step(1'b1, 1'b1, good2[31:24]);
        chk("mid_rxcmd_no_early", 96'(n_strobe), 96'd0);
        step(1'b1, 1'b0, 8'h00);
        chk("mid_rxcmd_pkt", {pkt_valid_o, pkt_len_o, pkt_data_o, pkt_crc_err_o, pkt_pid_err_o},
            {1'b1, 4'd2, 64'h2221, 1'b0, 1'b0});

        // Back-to-back: byte in EMIT is lost, next PID right after EMIT is taken
        step(1'b1, 1'b1, 8'h4B);
        chk("b2b_emit_valid_low", 96'(pkt_valid_o), 96'd0);
        step(1'b1, 1'b1, 8'hD2);
        chk("b2b_active", 96'(rx_active_o), 96'd1);
        step(1'b1, 1'b0, 8'h00);
        chk("b2b_ack", {pkt_valid_o, pkt_pid_o, pkt_len_o, pkt_pid_err_o, pkt_crc_err_o, pkt_ovf_o},
            {1'b1, 4'h2, 4'd0, 1'b0, 1'b0, 1'b0});
        step(1'b0, 1'b0, 8'h00);

        // Async reset mid-packet
        n_strobe = 0;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'hC3);
        step(1'b1, 1'b1, 8'h01);
        step(1'b1, 1'b1, 8'h02);
        step(1'b1, 1'b1, 8'h03);
        #2 rst = 1'b1;
        #1;
        chk("midrst_outputs", {16'h0, pkt_data_o, pkt_len_o, pkt_pid_o, pkt_valid_o, pkt_crc_err_o,
                               pkt_pid_err_o, pkt_ovf_o, rx_active_o, linestate_o, rx_cmd_valid_o}, 96'h0);
        dir_i = 1'b0; nxt_i = 1'b0;
        @(posedge usb_clk); #1 rst = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("midrst_no_strobe", 96'(n_strobe), 96'd0);
        run_vec(10, vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
